// File: rtl/pipelined_adder_pkg.sv
// Shared opcode constants and segment-width helper for the pipelined adder.
package pipelined_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational W-bit ripple adder slice; zero latency, no handshake.
// cm_o is the carry into the MSB, so the caller can form signed overflow as cm_o ^ co_o.
module adder_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         cm_o
);

  always_comb begin
    logic c;
    c    = ci_i;
    s_o  = '0;
    cm_o = ci_i;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      if (i == W - 1) cm_o = c;
      c = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/sub, STAGES-cycle latency, one global stall (out_valid && !out_ready) freezes every stage.
// Optional saturation on signed overflow when PIPELINED_ADDER_SAT_EN is defined.
import pipelined_adder_pkg::*;

module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG_W = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_err
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             fin_v;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sat_sum;
  logic             fin_co;
  logic             fin_cm;
  logic             ovf_w;
`ifdef PIPELINED_ADDER_SAT_EN
  logic             fin_amsb;
`endif

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // Subtraction is a + ~b + 1; cin only matters for addition.
  assign b_eff = (sub == OP_SUB) ? ~b : b;
  assign c_eff = (sub == OP_SUB) ? 1'b1 : cin;

  // Stage k owns segment k; its register carries the finished low sum bits
  // and only the still-unprocessed upper operand bits (skewed layout).
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int L = k * SEG_W;
    localparam int D = L + SEG_W;

    logic [WIDTH-L-1:0] src_a;
    logic [WIDTH-L-1:0] src_b;
    logic               src_c;
    logic               src_v;
    logic [SEG_W-1:0]   seg_s;
    logic               seg_co;
    logic               seg_cm;
    logic [D-1:0]       acc_s;

    if (k == 0) begin : g_src
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = c_eff;
      assign src_v = in_valid;
      assign acc_s = seg_s;
    end else begin : g_src
      assign src_a = g_stg[k-1].g_reg.a_q;
      assign src_b = g_stg[k-1].g_reg.b_q;
      assign src_c = g_stg[k-1].g_reg.c_q;
      assign src_v = g_stg[k-1].g_reg.v_q;
      assign acc_s = {seg_s, g_stg[k-1].g_reg.s_q};
    end

    adder_segment #(.W(SEG_W)) u_seg (
      .a_i  (src_a[SEG_W-1:0]),
      .b_i  (src_b[SEG_W-1:0]),
      .ci_i (src_c),
      .s_o  (seg_s),
      .co_o (seg_co),
      .cm_o (seg_cm)
    );

    if (k < STAGES - 1) begin : g_reg
      localparam int R = WIDTH - D;

      logic [R-1:0] a_q;
      logic [R-1:0] b_q;
      logic [D-1:0] s_q;
      logic         c_q;
      logic         v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (!stall) begin
          a_q <= src_a[WIDTH-L-1:SEG_W];
          b_q <= src_b[WIDTH-L-1:SEG_W];
          s_q <= acc_s;
          c_q <= seg_co;
          v_q <= src_v;
        end
      end
    end else begin : g_fin
      assign fin_v   = src_v;
      assign raw_sum = acc_s;
      assign fin_co  = seg_co;
      assign fin_cm  = seg_cm;
`ifdef PIPELINED_ADDER_SAT_EN
      assign fin_amsb = src_a[SEG_W-1];
`endif
    end
  end

  assign ovf_w = fin_cm ^ fin_co;

`ifdef PIPELINED_ADDER_SAT_EN
  // Overflow direction follows the operand sign: both positive clamps high.
  assign sat_sum = !ovf_w   ? raw_sum :
                   fin_amsb ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sat_sum = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= fin_v;
      sum_q       <= sat_sum;
      cout_q      <= fin_co;
      ovf_q       <= ovf_w;
      zero_q      <= (sat_sum == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: vector table, hand sequences and a random run against an arithmetic model.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int W = 32;
  localparam int S = 4;
`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, cin, sub, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] sum;
  logic         s1_in_ready, s1_out_valid, s1_cout, s1_ovf, s1_zero;
  logic [W-1:0] s1_sum;
  logic         s32_in_ready, s32_out_valid, s32_cout, s32_ovf, s32_zero;
  logic [W-1:0] s32_sum;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  pipelined_adder #(.WIDTH(W), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(s1_out_valid), .out_ready(out_ready), .sum(s1_sum),
    .cout(s1_cout), .ovf(s1_ovf), .zero(s1_zero));

  pipelined_adder #(.WIDTH(W), .STAGES(32)) dut_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s32_in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(s32_out_valid), .out_ready(out_ready), .sum(s32_sum),
    .cout(s32_cout), .ovf(s32_ovf), .zero(s32_zero));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         op;
    logic [W-1:0] s_wrap;
    logic [W-1:0] s_sat;
    logic         co;
    logic         ov;
    logic         z_wrap;
    logic         z_sat;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference: plain integer arithmetic, delayed through an S-slot line.
  logic         mv[S];
  res_t         mr[S];
  int           cyc = 0;
  int           acc_cyc = 0;
  bit           acc_flag;
  bit           out_seen;
  int           out_cyc;
  res_t         last_out;
  logic [W-1:0] got_q[$];
  int           got_c[$];
  int           s1_first, s32_first;
  res_t         s1_res, s32_res;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic op);
    res_t         r;
    longint       sx, sy, ex;
    logic [W:0]   u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == OP_SUB) begin
      r.sum  = x - y;
      r.cout = (x >= y);
      ex     = sx - sy;
    end else begin
      u      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.sum  = u[W-1:0];
      r.cout = u[W];
      ex     = sx + sy + (ci ? 64'sd1 : 64'sd0);
    end
    r.ovf = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    if (SAT && r.ovf) r.sum = (ex > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < S; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end
  endtask

  // One clock: sample and check at the falling edge, then step the model.
  task automatic cycle();
    logic m_stall;
    @(negedge clk);
    cyc++;
    m_stall = mv[S-1] && !out_ready;
    chk("out_valid", out_valid, mv[S-1]);
    chk("in_ready", in_ready, !m_stall);
    if (mv[S-1] && out_ready) begin
      chk("sum", sum, mr[S-1].sum);
      chk("cout", cout, mr[S-1].cout);
      chk("ovf", ovf, mr[S-1].ovf);
      chk("zero", zero, mr[S-1].zero);
      got_q.push_back(sum);
      got_c.push_back(cyc);
      last_out = {sum, cout, ovf, zero};
      out_seen = 1'b1;
      out_cyc  = cyc;
    end
    if (s1_out_valid && s1_first < 0) begin
      s1_first = cyc;
      s1_res   = {s1_sum, s1_cout, s1_ovf, s1_zero};
    end
    if (s32_out_valid && s32_first < 0) begin
      s32_first = cyc;
      s32_res   = {s32_sum, s32_cout, s32_ovf, s32_zero};
    end
    acc_flag = in_valid && !m_stall;
    if (!m_stall) begin
      for (int i = S - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = in_valid;
      mr[0] = model(a, b, cin, sub);
      if (in_valid) acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tv[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int sent;
    logic [W-1:0] sp[6];

    tv[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{32'h0000_0005, 32'h0000_0005, 1'b0, OP_SUB, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, OP_SUB, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[9] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b0, OP_ADD, 32'h2222_2220, 32'h2222_2220, 1'b0, 1'b0, 1'b0, 1'b0};
    sp[0] = 32'h0000_0000; sp[1] = 32'h0000_0001; sp[2] = 32'h7FFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'hFFFF_FFFF; sp[5] = 32'h0000_FFFF;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = OP_ADD; out_ready = 1'b1;
    clear_model();
    s1_first = -1; s32_first = -1; out_seen = 1'b0; out_cyc = 0; last_out = '0;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_flags", {cout, ovf, zero}, 3'b000);
    chk("rst_s1_s32_valid", {s1_out_valid, s32_out_valid}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full carry ripple, compared across STAGES = 4, 1 and 32
    chk("s1_s32_in_ready", {s1_in_ready, s32_in_ready}, 2'b11);
    a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = OP_ADD; in_valid = 1'b1;
    cycle();
    t0 = acc_cyc;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (s32_first < 0 || !out_seen); i++) cycle();
    chk("lat_s4", out_cyc - t0, S);
    chk("lat_s1", s1_first - t0, 1);
    chk("lat_s32", s32_first - t0, 32);
    chk("carry_s4", last_out, {32'h0, 1'b1, 1'b0, 1'b1});
    chk("carry_s1", s1_res, {32'h0, 1'b1, 1'b0, 1'b1});
    chk("carry_s32", s32_res, {32'h0, 1'b1, 1'b0, 1'b1});

    // Table of single beats
    for (int v = 0; v < 10; v++) begin
      out_seen = 1'b0;
      a = tv[v].a; b = tv[v].b; cin = tv[v].ci; sub = tv[v].op; in_valid = 1'b1;
      cycle();
      t0 = acc_cyc;
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_seen; i++) cycle();
      chk($sformatf("tv%0d_latency", v), out_cyc - t0, S);
      chk($sformatf("tv%0d_sum", v), last_out.sum, SAT ? tv[v].s_sat : tv[v].s_wrap);
      chk($sformatf("tv%0d_cout", v), last_out.cout, tv[v].co);
      chk($sformatf("tv%0d_ovf", v), last_out.ovf, tv[v].ov);
      chk($sformatf("tv%0d_zero", v), last_out.zero, SAT ? tv[v].z_sat : tv[v].z_wrap);
    end

    // Back-to-back subtracts come out on consecutive cycles
    got_q.delete(); got_c.delete();
    sub = OP_SUB; cin = 1'b0; in_valid = 1'b1;
    a = 32'd5; b = 32'd5; cycle();
    a = 32'd0; b = 32'd1; cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && got_q.size() < 2; i++) cycle();
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("b2b_first", got_q[0], 32'h0);
      chk("b2b_second", got_q[1], 32'hFFFF_FFFF);
      chk("b2b_gap", got_c[1] - got_c[0], 1);
    end

    // Backpressure: out_ready pattern 1,0,0 repeating
    got_q.delete(); got_c.delete();
    sent = 0; sub = OP_ADD; cin = 1'b0;
    for (int k = 0; k < 200 && got_q.size() < 8; k++) begin
      in_valid  = (sent < 8);
      a         = sent;
      b         = sent;
      out_ready = (k % 3 == 0);
      cycle();
      if (acc_flag) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) cycle();
    chk("bp_count", got_q.size(), 8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      chk($sformatf("bp_result%0d", i), got_q[i], 2 * i);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      cin = $urandom_range(0, 1);
      sub = $urandom_range(0, 1);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) cycle();

    // Reset with three beats stalled in flight
    out_ready = 1'b0; sub = OP_ADD; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'd100 + i; b = 32'd1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("pre_rst_out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 32'h0);
    chk("mid_rst_flags", {cout, ovf, zero}, 3'b000);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    got_q.delete(); got_c.delete();
    out_seen = 1'b0;
    a = 32'd7; b = 32'd8; in_valid = 1'b1;
    cycle();
    t0 = acc_cyc;
    in_valid = 1'b0;
    repeat (10) cycle();
    chk("post_rst_count", got_q.size(), 1);
    chk("post_rst_latency", out_cyc - t0, S);
    chk("post_rst_sum", last_out.sum, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
